spi_master: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) master controller that drives SCLK, SS and MOSI toward the team's SPI slave and captures MISO. It sits on the system side of the SPI link and generates SCLK from the system clock with a programmable divider. Each accepted start runs one full-duplex DATA_W-bit transfer, MSB first. The transfer ends with an SS-high deselect gap, so the slave's end-of-transaction logic always sees SS rise between words.

---
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master. SCLK comes from a programmable divider. Each start runs one
// MSB-first full-duplex word and ends with an SS-high deselect gap.
module spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned      CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned      BIT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic              sclk_q, ss_q, mosi_q, busy_q, done_q;

  // Every state change happens on a tick, so wrapping on tick doubles as the reload.
  always_comb begin
    tick  = (state_q != IDLE) && (cnt_q == CNT_LAST);
    cnt_d = ((state_q == IDLE) || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          ss_q   <= 1'b1;
          mosi_q <= 1'b0;
          if (start) begin
            tx_q    <= tx_data;
            rx_q    <= '0;
            bit_q   <= '0;
            ss_q    <= 1'b0;
            mosi_q  <= tx_data[DATA_W-1];
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        // The SETUP tick is also the first SCLK rise: one half-period from SS fall.
        SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[DATA_W-2:0], miso};
            bit_q   <= bit_q + BIT_W'(1);
            state_q <= XFER;
          end
        end
        XFER: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[DATA_W-2:0], miso};
              bit_q  <= bit_q + BIT_W'(1);
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= HOLD;
              end else begin
                tx_q   <= tx_q << 1;
                mosi_q <= tx_q[DATA_W-2];
              end
            end
          end
        end
        HOLD: begin
          sclk_q <= 1'b0;
          if (tick) begin
            ss_q      <= 1'b1;
            rx_data_q <= rx_q;
            done_q    <= 1'b1;
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=2 instance for protocol/timing cases and
// a CLK_DIV=255 instance for the divider extreme. Observation point N = just before edge N.
module tb_spi_master;

  localparam int MAXC = 4700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start_a, start_b;
  logic [7:0] tx_a, tx_b;
  logic       loop_a, miso_frc;
  logic       busy_a, done_a, sclk_a, ss_a, mosi_a, miso_a;
  logic       busy_b, done_b, sclk_b, ss_b, mosi_b, miso_b;
  logic [7:0] rx_a, rx_b;

  assign miso_a = loop_a ? mosi_a : miso_frc;
  assign miso_b = mosi_b;

  spi_master #(.CLK_DIV(2), .DATA_W(8)) u_a (
    .clk(clk), .rstn(rstn), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CLK_DIV(255), .DATA_W(8)) u_b (
    .clk(clk), .rstn(rstn), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       t_sclk [MAXC];
  logic       t_ss   [MAXC];
  logic       t_mosi [MAXC];
  logic       t_busy [MAXC];
  logic       t_done [MAXC];
  logic [7:0] t_rx   [MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick(input bit use_b, input logic [7:0] d);
    @(negedge clk);
    if (use_b) begin start_b = 1'b1; tx_b = d; end
    else       begin start_a = 1'b1; tx_a = d; end
  endtask

  // Records cycles 1..ncyc after the acceptance edge; pulses start at p1/p2/p3.
  task automatic capture(input bit use_b, input int ncyc, input int p1, input int p2,
                         input int p3, input logic [7:0] pdata);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      t_sclk[c] = use_b ? sclk_b : sclk_a;
      t_ss[c]   = use_b ? ss_b   : ss_a;
      t_mosi[c] = use_b ? mosi_b : mosi_a;
      t_busy[c] = use_b ? busy_b : busy_a;
      t_done[c] = use_b ? done_b : done_a;
      t_rx[c]   = use_b ? rx_b   : rx_a;
      if (c == p1 || c == p2 || c == p3) begin
        if (use_b) begin start_b = 1'b1; tx_b = pdata; end
        else       begin start_a = 1'b1; tx_a = pdata; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (t_done[c]) n++;
    return n;
  endfunction

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    for (int c = lo + 1; c <= hi; c++) if (!t_sclk[c-1] && t_sclk[c]) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         ones;
    int         last;
    rstn = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_a = '0; tx_b = '0;
    loop_a = 1'b1; miso_frc = 1'b0;

    // Asynchronous reset, asserted mid-cycle
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_ss",   32'(ss_a),   32'd1);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rx",   32'(rx_a),   32'd0);
    chk("rst_ss_b", 32'(ss_b),   32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Loopback 0xA5, CLK_DIV=2
    pat = 8'hA5;
    kick(1'b0, pat);
    capture(1'b0, 40, 0, 0, 0, 8'h00);
    chk("lb_ss_fall",   32'(t_ss[1]),   32'd0);
    chk("lb_busy_rise", 32'(t_busy[1]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("lb_sclk_rise", 32'({t_sclk[2+4*k], t_sclk[3+4*k]}), 32'b01);
      chk("lb_mosi_bit",  32'(t_mosi[3+4*k]), 32'(pat[7-k]));
    end
    chk("lb_last_fall", 32'({t_sclk[32], t_sclk[33]}), 32'b10);
    chk("lb_done_pre",  32'(t_done[34]), 32'd0);
    chk("lb_done",      32'(t_done[35]), 32'd1);
    chk("lb_done_post", 32'(t_done[36]), 32'd0);
    chk("lb_rx",        32'(t_rx[35]),   32'hA5);
    chk("lb_ss_rise",   32'({t_ss[34], t_ss[35]}),     32'b01);
    chk("lb_busy_fall", 32'({t_busy[36], t_busy[37]}), 32'b10);
    chk("lb_mosi_idle", 32'(t_mosi[37]), 32'd0);

    // Independent MISO held high, tx 0x00
    loop_a = 1'b0; miso_frc = 1'b1;
    kick(1'b0, 8'h00);
    capture(1'b0, 40, 0, 0, 0, 8'h00);
    ones = 0;
    for (int c = 1; c <= 40; c++) if (t_mosi[c]) ones++;
    chk("ind_mosi_ones", 32'(ones), 32'd0);
    chk("ind_rises",     32'(count_rises(1, 40)), 32'd8);
    chk("ind_rx",        32'(t_rx[35]), 32'hFF);
    chk("ind_ss_fall",   32'(t_ss[1]), 32'd0);
    chk("ind_ss_rise",   32'({t_ss[34], t_ss[35]}), 32'b01);
    loop_a = 1'b1; miso_frc = 1'b0;

    // Start while busy at cycles 5 and 35 ignored; cycle 37 accepted
    kick(1'b0, 8'hA5);
    capture(1'b0, 75, 5, 35, 37, 8'h3C);
    chk("sb_done_once",  32'(count_done(1, 36)), 32'd1);
    chk("sb_rx_first",   32'(t_rx[35]), 32'hA5);
    chk("sb_busy_37",    32'(t_busy[37]), 32'd0);
    chk("sb_busy_38",    32'(t_busy[38]), 32'd1);
    chk("sb_ss_38",      32'(t_ss[38]), 32'd0);
    chk("sb_done_total", 32'(count_done(1, 75)), 32'd2);
    chk("sb_done_2nd",   32'(t_done[72]), 32'd1);
    chk("sb_rx_second",  32'(t_rx[72]), 32'h3C);

    // Reset at cycle 15 of a 0xC3 transfer
    kick(1'b0, 8'hC3);
    capture(1'b0, 15, 0, 0, 0, 8'h00);
    chk("mr_pre_sclk", 32'(t_sclk[15]), 32'd1);
    chk("mr_pre_ss",   32'(t_ss[15]),   32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("mr_ss",   32'(ss_a),   32'd1);
    chk("mr_sclk", 32'(sclk_a), 32'd0);
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_done", 32'(done_a), 32'd0);
    chk("mr_rx",   32'(rx_a),   32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    capture(1'b0, 40, 0, 0, 0, 8'h00);
    chk("mr_no_done", 32'(count_done(1, 40)), 32'd0);
    chk("mr_rx_held", 32'(t_rx[40]), 32'd0);
    kick(1'b0, 8'h5A);
    capture(1'b0, 40, 0, 0, 0, 8'h00);
    chk("mr_new_done", 32'(t_done[35]), 32'd1);
    chk("mr_new_rx",   32'(t_rx[35]),   32'h5A);

    // Divider extreme, CLK_DIV=255, loopback 0x81
    kick(1'b1, 8'h81);
    capture(1'b1, 4600, 0, 0, 0, 8'h00);
    chk("dv_first_rise", 32'({t_sclk[255], t_sclk[256]}), 32'b01);
    chk("dv_rises",      32'(count_rises(1, 4600)), 32'd8);
    last = 0;
    for (int c = 2; c <= 4600; c++) begin
      if (t_sclk[c] != t_sclk[c-1]) begin
        if (t_sclk[c-1])    chk("dv_hi_len", 32'(c - last), 32'd255);
        else if (last != 0) chk("dv_lo_len", 32'(c - last), 32'd255);
        last = c;
      end
    end
    chk("dv_done",      32'(t_done[4336]), 32'd1);
    chk("dv_rx",        32'(t_rx[4336]),   32'h81);
    chk("dv_busy_fall", 32'({t_busy[4590], t_busy[4591]}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
